// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and default baud divisor.
// The encoding is also meant for the matching receiver.
package uart_pkg;

  localparam int CLKS_PER_BIT_115200 = 434;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last two cycles of
// each bit period. clear restarts the period so a new frame is phase-aligned.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic bit_end,
  output logic bit_pre_end
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bit_end     = (r_cnt == CNT_LAST);
  assign bit_pre_end = (r_cnt == CNT_PRE);

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised RS232 frame transmitter (start, DATA_BITS LSB-first, stop bits).
// Define UART_TX_PARITY_EN to add the parity_odd port and a parity bit.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
`ifdef UART_TX_PARITY_EN
  input  logic                 parity_odd,
`endif
  output logic                 active,
  output logic                 done,
  output logic                 tx
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  uart_state_e          r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_stop_cnt;
  logic                 w_accept;
  logic                 w_bit_end;
  logic                 w_bit_pre_end;
  logic [IDX_W-1:0]     w_idx_nxt;

  assign w_accept  = tx_valid && tx_ready;
  assign w_idx_nxt = r_idx + 1'b1;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clock      (clock),
    .reset      (reset),
    .clear      (w_accept),
    .bit_end    (w_bit_end),
    .bit_pre_end(w_bit_pre_end)
  );

`ifdef UART_TX_PARITY_EN
  logic r_par_odd;
  logic w_parity;
  assign w_parity = (^r_shift) ^ r_par_odd;

  always_ff @(posedge clock) begin
    if (w_accept) r_par_odd <= parity_odd;
  end
`endif

  // Word is captured only at acceptance; later bus changes cannot disturb the frame.
  always_ff @(posedge clock) begin
    if (w_accept) r_shift <= tx_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_stop_cnt <= 1'b0;
      tx         <= 1'b1;
      tx_ready   <= 1'b1;
      active     <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state  <= START;
            tx       <= 1'b0;
            tx_ready <= 1'b0;
            active   <= 1'b1;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_state <= DATA;
            r_idx   <= '0;
            tx      <= r_shift[0];
          end
        end
        DATA: begin
          if (w_bit_end) begin
            if (r_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
              r_state <= PARITY;
              tx      <= w_parity;
`else
              r_state    <= STOP;
              r_stop_cnt <= 1'b0;
              tx         <= 1'b1;
`endif
            end else begin
              r_idx <= w_idx_nxt;
              tx    <= r_shift[w_idx_nxt];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_bit_end) begin
            r_state    <= STOP;
            r_stop_cnt <= 1'b0;
            tx         <= 1'b1;
          end
        end
`endif
        STOP: begin
          // done is registered, so it is raised one cycle early to land on the final cycle.
          if (w_bit_pre_end && (r_stop_cnt == STOP_LAST)) done <= 1'b1;
          if (w_bit_end) begin
            if (r_stop_cnt == STOP_LAST) begin
              r_state  <= IDLE;
              active   <= 1'b0;
              tx_ready <= 1'b1;
            end else begin
              r_stop_cnt <= r_stop_cnt + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: 8N1 and 7-data/2-stop instances, per-cycle
// scoreboard of the expected tx waveform; parity expectations follow UART_TX_PARITY_EN.
module tb_uart_tx_frame;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a_data;
  logic       a_valid, a_ready, a_active, a_done, a_tx;
  logic [6:0] b_data;
  logic       b_valid, b_ready, b_active, b_done, b_tx;
`ifdef UART_TX_PARITY_EN
  logic       a_par, b_par;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) u_a (
    .clock(clk), .reset(rst), .tx_data(a_data), .tx_valid(a_valid), .tx_ready(a_ready),
`ifdef UART_TX_PARITY_EN
    .parity_odd(a_par),
`endif
    .active(a_active), .done(a_done), .tx(a_tx)
  );

  uart_tx_frame #(.DATA_BITS(7), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_b (
    .clock(clk), .reset(rst), .tx_data(b_data), .tx_valid(b_valid), .tx_ready(b_ready),
`ifdef UART_TX_PARITY_EN
    .parity_odd(b_par),
`endif
    .active(b_active), .done(b_done), .tx(b_tx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic g_tx(input bit sel);     return sel ? b_tx : a_tx;         endfunction
  function automatic logic g_ready(input bit sel);  return sel ? b_ready : a_ready;   endfunction
  function automatic logic g_active(input bit sel); return sel ? b_active : a_active; endfunction
  function automatic logic g_done(input bit sel);   return sel ? b_done : a_done;     endfunction

  task automatic drive(input bit sel, input logic v, input logic [8:0] d, input logic po);
    if (sel) begin
      b_valid = v; b_data = d[6:0];
`ifdef UART_TX_PARITY_EN
      b_par = po;
`endif
    end else begin
      a_valid = v; a_data = d[7:0];
`ifdef UART_TX_PARITY_EN
      a_par = po;
`endif
    end
  endtask

  task automatic idle_chk(input bit sel, input string tag);
    chk({tag, " tx"},     32'(g_tx(sel)),     32'd1);
    chk({tag, " ready"},  32'(g_ready(sel)),  32'd1);
    chk({tag, " active"}, 32'(g_active(sel)), 32'd0);
    chk({tag, " done"},   32'(g_done(sel)),   32'd0);
  endtask

  // Offer d, then follow the frame cycle by cycle. d_mid is driven during the frame,
  // keep leaves tx_valid high afterwards, abort_at>=0 pulses reset at that cycle.
  task automatic frame(input bit sel, input logic [8:0] d, input logic [8:0] d_mid,
                       input bit keep, input logic po, input int abort_at);
    int        nb = sel ? 7 : 8;
    int        ns = sel ? 2 : 1;
    logic [8:0] dm = sel ? (d & 9'h07F) : (d & 9'h0FF);
    logic       pbit = (^dm) ^ po;
    logic       e;
    string      nm = sel ? "B" : "A";
    drive(sel, 1'b1, d, po);
    chk($sformatf("%s %0h ready_pre", nm, d), 32'(g_ready(sel)), 32'd1);
    for (int k = 0; k < CPB; k++) exp_q.push_back(1'b0);
    for (int i = 0; i < nb; i++) for (int k = 0; k < CPB; k++) exp_q.push_back(dm[i]);
    if (PAR_EN) for (int k = 0; k < CPB; k++) exp_q.push_back(pbit);
    for (int k = 0; k < ns * CPB; k++) exp_q.push_back(1'b1);
    tick();
    for (int c = 0; exp_q.size() > 0; c++) begin
      if (c == 0) drive(sel, keep, d, ~po);
      if (c == 10) drive(sel, keep, d_mid, ~po);
      if (c == abort_at) begin
        rst = 1'b1;
        drive(sel, 1'b1, d_mid, po);
        tick();
        rst = 1'b0;
        drive(sel, 1'b0, d_mid, po);
        idle_chk(sel, $sformatf("%s abort c%0d", nm, c));
        exp_q.delete();
        for (int k = 0; k < 2 * CPB; k++) begin
          tick();
          idle_chk(sel, $sformatf("%s post_abort k%0d", nm, k));
        end
        return;
      end
      e = exp_q.pop_front();
      chk($sformatf("%s %0h tx c%0d", nm, d, c),     32'(g_tx(sel)),     32'(e));
      chk($sformatf("%s %0h active c%0d", nm, d, c), 32'(g_active(sel)), 32'd1);
      chk($sformatf("%s %0h ready c%0d", nm, d, c),  32'(g_ready(sel)),  32'd0);
      chk($sformatf("%s %0h done c%0d", nm, d, c),   32'(g_done(sel)),
          32'(exp_q.size() == 0));
      tick();
    end
    idle_chk(sel, $sformatf("%s %0h end", nm, d));
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b1, 9'h0A5, 1'b0);
    drive(1'b1, 1'b1, 9'h055, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 9'h0A5, 1'b0);
    drive(1'b1, 1'b0, 9'h055, 1'b0);
    idle_chk(1'b0, "A reset");
    idle_chk(1'b1, "B reset");
    tick();
    idle_chk(1'b0, "A after_reset");

    frame(1'b0, 9'h0A5, 9'h0A5, 1'b0, 1'b0, -1);
    frame(1'b0, 9'h0A5, 9'h0A5, 1'b0, 1'b1, -1);

    frame(1'b0, 9'h000, 9'h0FF, 1'b1, 1'b0, -1);
    frame(1'b0, 9'h0FF, 9'h0FF, 1'b0, 1'b0, -1);
    for (int k = 0; k < 6; k++) begin
      tick();
      idle_chk(1'b0, $sformatf("A no_third k%0d", k));
    end

    frame(1'b1, 9'h07F, 9'h000, 1'b0, 1'b0, -1);
    frame(1'b1, 9'h02A, 9'h055, 1'b0, 1'b1, -1);

    frame(1'b0, 9'h0C3, 9'h0C3, 1'b0, 1'b0, 17);
    frame(1'b0, 9'h03C, 9'h03C, 1'b0, 1'b0, -1);

    frame(1'b0, 9'h0A5, 9'h05A, 1'b0, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Parametrised RS232 transmitter; next generation of the team's fixed 8N1 UART emitter.
- Serialises one word per handshake as start bit, DATA_BITS data bits (LSB first), optional parity bit, and 1 or 2 stop bits.
- Each bit lasts exactly CLKS_PER_BIT clocks.
- Sits between a bus-side producer (ready/valid) and the external tx pin.

Parameters:
- DATA_BITS, 8, data bits per frame; legal 5..9.
- CLKS_PER_BIT, 434, clock cycles per bit; 50 MHz / 115200 baud; legal >= 2.
- STOP_BITS, 1, number of stop bits; legal 1 or 2.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- tx_data  in  DATA_BITS  word to send; sampled only at acceptance.
- tx_valid  in  1  producer has a word.
- tx_ready  out  1  block can accept a word.
- parity_odd  in  1  parity mode, 1 = odd, 0 = even; present only with UART_TX_PARITY_EN.
- active  out  1  high for the whole frame.
- done  out  1  one-cycle pulse at frame end.
- tx  out  1  serial line; idle high.

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high.
- Reset values: tx=1, tx_ready=1, active=0, done=0, state=IDLE, bit counter=0, bit index=0.
- All outputs are registered.
- States: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE:
  - tx=1, tx_ready=1, active=0.
  - On tx_valid&&tx_ready at an edge: latch tx_data and parity_odd into the shift register; go to START.
  - At that same edge: tx_ready->0, active->1, tx->0.
  - Latency: tx falls on the first edge after acceptance.
- START:
  - tx=0 for CLKS_PER_BIT cycles, counted from the acceptance edge.
  - Then go to DATA with index 0.
- DATA:
  - tx=shift[index] for CLKS_PER_BIT cycles per bit; index increments.
  - After index DATA_BITS-1, go to PARITY if compiled in, else STOP.
- PARITY:
  - tx=XOR of the latched word, XOR latched parity_odd, for CLKS_PER_BIT cycles.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the final cycle: done=1 for exactly one cycle; next edge goes to IDLE with active=0, tx_ready=1.
- Bit timing:
  - Counter width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1, wraps to 0 on each bit boundary.
  - No extra hold cycle per bit: frame length is exactly (1+DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT, with P=1 when parity is compiled in.
- Back-to-back frames: if tx_valid is held, the next word is accepted in the single IDLE cycle. Minimum gap is one extra idle-high cycle between frames.
- tx_data and tx_valid changes while tx_ready=0 are ignored; the frame is unaffected.
- Reset mid-frame:
  - Frame aborted; tx=1 on the reset edge; no done pulse.
  - A word offered during reset is not accepted.
- tx_valid asserted in the same cycle as reset: ignored.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: parity_odd port present, PARITY state inserted after the data bits; frame grows by CLKS_PER_BIT cycles.
- Undefined: parity_odd port, PARITY state and parity logic are absent. Frame is start + data + stop only.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP), shared with a future uart_rx_frame;
  - the default constant CLKS_PER_BIT_115200=434.
- One natural sub-module: uart_baud_tick.
  - Parameter CLKS_PER_BIT; inputs clock, reset, clear.
  - Outputs bit_end, pulsing on the last cycle of each bit period.
  - Counter is cleared on acceptance.
- The top holds the FSM, shift register, stop-bit counter and parity.

Test Plan (CLKS_PER_BIT=4 unless stated):
- DATA_BITS=8, STOP_BITS=1, send 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each 4 cycles. active high for 40 cycles; done pulses on cycle 40; tx_ready returns one cycle later.
- tx_valid held with 0x00 then 0xFF -> two 40-cycle frames separated by exactly one idle-high cycle; each word accepted once; two done pulses.
- STOP_BITS=2, DATA_BITS=7, send 0x7F -> start 0, seven 1s, 8 stop cycles high; frame 40 cycles total; bit 7 of the input is ignored.
- UART_TX_PARITY_EN defined, send 0xA5 (four ones):
  - parity_odd=0 -> parity bit 0;
  - parity_odd=1 -> parity bit 1;
  - frame is 44 cycles in both cases.
- Assert reset for 1 cycle during data bit 3 -> tx=1 on the next edge, no done pulse, tx_ready=1. A following 0x3C frame is bit-exact.
- Change tx_data mid-frame from 0xA5 to 0x5A -> transmitted bits still match 0xA5.
